arbitro_memoria: RTL

Two-requester arbiter that shares one single-port word memory between the RV32I instruction fetch and the load/store unit. It accepts requests on two req/pronto handshake ports and serializes them onto one mem_req/mem_ack port with round-robin priority. It returns read data to the winning requester and substitutes a NOP or zero on a memory timeout. It sits between the core and the unified memory, replacing the direct combinational ROM path once instructions and data share storage.

---
 rtl/arbitro_memoria.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter sharing one single-port word memory between instruction fetch
// and the load/store unit, with per-transaction timeout and NOP/zero substitution.

module arbitro_memoria_porta #(
  parameter logic [31:0] VAZIO = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        captura,
  input  logic        ack,
  input  logic [31:0] rdata,
  output logic [31:0] dado
);
  // On a timeout the port gets its own fill value instead of memory data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dado <= '0;
    else if (captura) dado <= ack ? rdata : VAZIO;
  end
endmodule

module arbitro_memoria #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_req,
  input  logic [31:0] inst_endereco,
  output logic        inst_pronto,
  output logic [31:0] inst_dado,
  input  logic        dados_req,
  input  logic        dados_we,
  input  logic [3:0]  dados_be,
  input  logic [31:0] dados_endereco,
  input  logic [31:0] dados_wdata,
  output logic        dados_pronto,
  output logic [31:0] dados_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_endereco,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        erro_timeout
);
  localparam int          CW     = $clog2(TIMEOUT + 1);
  localparam int          NPORTS = 2;
  localparam logic        P_INST  = 1'b0;
  localparam logic        P_DADOS = 1'b1;
  localparam logic [NPORTS-1:0][31:0] VAZIO = {32'h0000_0000, 32'h0000_0013};

  typedef enum logic [1:0] {OCIOSO, ACESSO, CONCLUI} estado_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] endereco;
    logic [31:0] wdata;
  } mem_op_t;

  estado_t                  estado, prox;
  logic                     ultimo;
  logic                     venc;
  logic                     concede;
  logic                     fim_to;
  logic [CW-1:0]            cnt;
  mem_op_t                  op_q, op_d;
  logic [NPORTS-1:0]        captura;
  logic [NPORTS-1:0][31:0]  dado_porta;

  assign concede = (estado == OCIOSO) && (inst_req || dados_req);
  // On a tie, the requester that did not win last time goes first.
  assign venc    = (inst_req && dados_req) ? ~ultimo : (dados_req ? P_DADOS : P_INST);
  assign fim_to  = (estado == ACESSO) && !mem_ack && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    if (venc == P_DADOS)
      op_d = '{we: dados_we, be: (dados_we ? dados_be : 4'hF),
               endereco: dados_endereco, wdata: dados_wdata};
    else
      op_d = '{we: 1'b0, be: 4'hF,
               endereco: (inst_endereco & ~32'h3), wdata: 32'h0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  if (inst_req || dados_req) prox = ACESSO;
      ACESSO:  if (mem_ack || fim_to)      prox = CONCLUI;
      CONCLUI: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_comb begin
    mem_req      = (estado == ACESSO);
    inst_pronto  = (estado == CONCLUI) && (ultimo == P_INST);
    dados_pronto = (estado == CONCLUI) && (ultimo == P_DADOS);
    captura      = '0;
    if (estado == ACESSO && (mem_ack || fim_to)) begin
      captura[0] = (ultimo == P_INST);
      captura[1] = (ultimo == P_DADOS) && !op_q.we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ultimo       <= P_DADOS;
      op_q         <= '0;
      cnt          <= '0;
      erro_timeout <= 1'b0;
    end else begin
      if (concede) begin
        ultimo <= venc;
        op_q   <= op_d;
        cnt    <= '0;
      end else if (estado == ACESSO && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (fim_to) erro_timeout <= 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NPORTS; g++) begin : g_porta
      arbitro_memoria_porta #(.VAZIO(VAZIO[g])) u_porta (
        .clk     (clk),
        .rst_n   (rst_n),
        .captura (captura[g]),
        .ack     (mem_ack),
        .rdata   (mem_rdata),
        .dado    (dado_porta[g])
      );
    end
  endgenerate

  assign inst_dado    = dado_porta[0];
  assign dados_rdata  = dado_porta[1];
  assign mem_we       = op_q.we;
  assign mem_be       = op_q.be;
  assign mem_endereco = op_q.endereco;
  assign mem_wdata    = op_q.wdata;
endmodule
